// File: rtl/uart_rx_param_if.sv
// Received-word channel of uart_rx_param: data, parity flag and the valid/ready pair.
// A word moves when m_valid && m_ready at a rising clk edge; m_data/m_parity_err hold steady while m_valid waits for m_ready.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_parity_err;

  modport master (output m_data, output m_valid, output m_parity_err, input m_ready);
  modport slave  (input m_data, input m_valid, input m_parity_err, output m_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with input synchroniser, holding register and error flags.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  uart_rx_param_if.master     m,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy,
  output logic                break_det,
  output logic [2:0]          dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
`ifdef UART_RX_BREAK_DETECT_EN
    , BRK_WAIT = 3'd6
`endif
  } state_t;

  state_t               r_state, w_state_n;
  logic                 r_sync1, r_sync2;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [IW-1:0]        r_idx, w_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_perr_int, w_perr_int_n;
  logic                 r_ferr_int, w_ferr_int_n;
  logic [DATA_BITS-1:0] r_data, w_data_n;
  logic                 r_valid, w_valid_n;
  logic                 r_mperr, w_mperr_n;
  logic                 r_ferr_p, w_ferr_p_n;
  logic                 r_ovr_p, w_ovr_p_n;
  logic                 w_rx_s;
  logic                 w_par_exp;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 r_zero, w_zero_n;
  logic                 r_brk_p, w_brk_p_n;
`endif

  assign w_rx_s    = r_sync2;
  assign w_par_exp = (^r_shift) ^ (PARITY_MODE == 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_perr_int <= 1'b0;
      r_ferr_int <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_mperr    <= 1'b0;
      r_ferr_p   <= 1'b0;
      r_ovr_p    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_zero     <= 1'b0;
      r_brk_p    <= 1'b0;
`endif
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_shift    <= w_shift_n;
      r_perr_int <= w_perr_int_n;
      r_ferr_int <= w_ferr_int_n;
      r_data     <= w_data_n;
      r_valid    <= w_valid_n;
      r_mperr    <= w_mperr_n;
      r_ferr_p   <= w_ferr_p_n;
      r_ovr_p    <= w_ovr_p_n;
`ifdef UART_RX_BREAK_DETECT_EN
      r_zero     <= w_zero_n;
      r_brk_p    <= w_brk_p_n;
`endif
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_idx_n      = r_idx;
    w_shift_n    = r_shift;
    w_perr_int_n = r_perr_int;
    w_ferr_int_n = r_ferr_int;
    w_data_n     = r_data;
    w_valid_n    = r_valid && !m.m_ready;
    w_mperr_n    = r_mperr;
    w_ferr_p_n   = 1'b0;
    w_ovr_p_n    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    w_zero_n     = r_zero;
    w_brk_p_n    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        w_idx_n = '0;
        if (!w_rx_s) begin
          w_state_n    = START;
          w_perr_int_n = 1'b0;
          w_ferr_int_n = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
          w_zero_n     = 1'b1;
`endif
        end
      end
      START: begin
        if (r_cnt == HALF_TC) begin
          w_cnt_n   = '0;
          w_state_n = w_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == BIT_TC) begin
          // LSB arrives first, so shifting in from the top leaves it at bit 0.
          w_shift_n = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_cnt_n   = '0;
`ifdef UART_RX_BREAK_DETECT_EN
          w_zero_n  = r_zero && !w_rx_s;
`endif
          if (r_idx == IW'(DATA_BITS - 1)) begin
            w_idx_n   = '0;
            w_state_n = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            w_idx_n = r_idx + IW'(1);
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      PARITY: begin
        if (r_cnt == BIT_TC) begin
          w_perr_int_n = (w_rx_s != w_par_exp);
          w_cnt_n      = '0;
          w_state_n    = STOP;
`ifdef UART_RX_BREAK_DETECT_EN
          w_zero_n     = r_zero && !w_rx_s;
`endif
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_cnt == BIT_TC) begin
          w_cnt_n = '0;
          if (!w_rx_s) w_ferr_int_n = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
          w_zero_n = r_zero && !w_rx_s;
`endif
          if (r_idx == IW'(STOP_BITS - 1)) begin
            w_idx_n   = '0;
            w_state_n = DONE;
          end else begin
            w_idx_n = r_idx + IW'(1);
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state_n = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
        if (r_zero) begin
          w_brk_p_n = 1'b1;
          w_state_n = BRK_WAIT;
        end else
`endif
        if (r_ferr_int) begin
          w_ferr_p_n = 1'b1;
        end else if (r_valid && !m.m_ready) begin
          w_ovr_p_n = 1'b1;
        end else begin
          w_data_n  = r_shift;
          w_mperr_n = r_perr_int;
          w_valid_n = 1'b1;
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      BRK_WAIT: begin
        if (w_rx_s) w_state_n = IDLE;
      end
`endif
      default: w_state_n = IDLE;
    endcase
  end

  assign m.m_data       = r_data;
  assign m.m_valid      = r_valid;
  assign m.m_parity_err = r_mperr;
  assign frame_err      = r_ferr_p;
  assign overrun        = r_ovr_p;
  assign busy           = (r_state != IDLE);
  assign dbg_state      = r_state;
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det      = r_brk_p;
`else
  assign break_det      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver (a) and an even-parity, two-stop receiver (b).
// With UART_RX_BREAK_DETECT_EN defined the held-low case exercises break detection instead of framing errors.
module tb_uart_rx_param;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  always #5 clk = ~clk;

  logic       ferr_a, ovr_a, busy_a, brk_a;
  logic       ferr_b, ovr_b, busy_b, brk_b;
  logic [2:0] dbg_a, dbg_b;

  uart_rx_param_if #(.DATA_BITS(8)) a_if ();
  uart_rx_param_if #(.DATA_BITS(8)) b_if ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .m(a_if),
    .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a), .break_det(brk_a), .dbg_state(dbg_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .m(b_if),
    .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b), .break_det(brk_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] got_q_a[$], got_q_b[$];
  logic [8:0] exp_q_a[$], exp_q_b[$];
  int ferr_cnt_a = 0, ovr_cnt_a = 0, brk_cnt_a = 0, vcyc_a = 0, both_a = 0;
  int ferr_cnt_b = 0, ovr_cnt_b = 0, brk_cnt_b = 0, vcyc_b = 0, both_b = 0;
  int busy_seen_a = 0;

  always @(negedge clk) begin
    if (a_if.m_valid && a_if.m_ready) got_q_a.push_back({a_if.m_parity_err, a_if.m_data});
    if (b_if.m_valid && b_if.m_ready) got_q_b.push_back({b_if.m_parity_err, b_if.m_data});
    if (a_if.m_valid) vcyc_a++;
    if (b_if.m_valid) vcyc_b++;
    if (ferr_a) ferr_cnt_a++;
    if (ferr_b) ferr_cnt_b++;
    if (ovr_a) ovr_cnt_a++;
    if (ovr_b) ovr_cnt_b++;
    if (brk_a) brk_cnt_a++;
    if (brk_b) brk_cnt_b++;
    if (ferr_a && ovr_a) both_a++;
    if (ferr_b && ovr_b) both_b++;
    if (busy_a) busy_seen_a = 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_queue(input int sel);
    if (sel == 0) begin
      check_eq("a_word_count", got_q_a.size(), exp_q_a.size());
      for (int i = 0; i < exp_q_a.size(); i++)
        if (i < got_q_a.size()) check_eq($sformatf("a_word%0d", i), got_q_a[i], exp_q_a[i]);
      got_q_a.delete();
      exp_q_a.delete();
    end else begin
      check_eq("b_word_count", got_q_b.size(), exp_q_b.size());
      for (int i = 0; i < exp_q_b.size(); i++)
        if (i < got_q_b.size()) check_eq($sformatf("b_word%0d", i), got_q_b[i], exp_q_b[i]);
      got_q_b.delete();
      exp_q_b.delete();
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int sel, input int n);
    set_line(sel, 1'b1);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input int nstop, input logic s2);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, pbit);
    drive_bit(sel, 1'b1);
    if (nstop == 2) drive_bit(sel, s2);
    set_line(sel, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int snap_v, snap_f;

  initial begin
    a_if.m_ready = 1'b1;
    b_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_a_valid", a_if.m_valid, 0);
    check_eq("rst_a_data", a_if.m_data, 0);
    check_eq("rst_a_busy", busy_a, 0);
    check_eq("rst_a_state", dbg_a, 0);
    check_eq("rst_b_valid", b_if.m_valid, 0);
    check_eq("rst_b_perr", b_if.m_parity_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // back-to-back 8N1 words with the consumer always ready
    send_frame(0, 8'h55, 0, 1'b0, 1, 1'b1);
    send_frame(0, 8'hA3, 0, 1'b0, 1, 1'b1);
    idle_bits(0, 3);
    exp_q_a.push_back(9'h055);
    exp_q_a.push_back(9'h0A3);
    check_queue(0);
    check_eq("a_valid_cycles", vcyc_a, 2);
    check_eq("a_ferr_none", ferr_cnt_a, 0);
    check_eq("a_ovr_none", ovr_cnt_a, 0);

    // overrun: consumer stalled across two frames
    @(posedge clk); #1 a_if.m_ready = 1'b0;
    @(negedge clk);
    send_frame(0, 8'h11, 0, 1'b0, 1, 1'b1);
    send_frame(0, 8'h22, 0, 1'b0, 1, 1'b1);
    idle_bits(0, 2);
    check_eq("ovr_valid_held", a_if.m_valid, 1);
    check_eq("ovr_data_held", a_if.m_data, 8'h11);
    check_eq("ovr_pulse_count", ovr_cnt_a, 1);
    check_eq("ovr_no_ferr", ferr_cnt_a, 0);
    @(posedge clk); #1 a_if.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("ovr_valid_drop", a_if.m_valid, 0);
    exp_q_a.push_back(9'h011);
    check_queue(0);

    // short low glitch on the line
    snap_v = vcyc_a;
    snap_f = ferr_cnt_a;
    busy_seen_a = 0;
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(0, 2);
    check_eq("glitch_busy_seen", busy_seen_a, 1);
    check_eq("glitch_busy_end", busy_a, 0);
    check_eq("glitch_no_valid", vcyc_a - snap_v, 0);
    check_eq("glitch_no_ferr", ferr_cnt_a - snap_f, 0);

`ifdef UART_RX_BREAK_DETECT_EN
    // break: line held low for 30 bit times
    snap_f = ferr_cnt_a;
    rx_a = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    check_eq("brk_busy_mid", busy_a, 1);
    repeat (15 * CPB) @(negedge clk);
    check_eq("brk_pulse_count", brk_cnt_a, 1);
    check_eq("brk_no_ferr", ferr_cnt_a - snap_f, 0);
    check_eq("brk_busy_wait", busy_a, 1);
    idle_bits(0, 2);
    check_eq("brk_busy_end", busy_a, 0);
    send_frame(0, 8'h5A, 0, 1'b0, 1, 1'b1);
    idle_bits(0, 2);
    exp_q_a.push_back(9'h05A);
    check_queue(0);
`else
    // held low for one frame time: a framing error, then the restart sees the line return
    snap_v = vcyc_a;
    snap_f = ferr_cnt_a;
    rx_a = 1'b0;
    repeat (10 * CPB) @(negedge clk);
    idle_bits(0, 3);
    check_eq("low_ferr_count", ferr_cnt_a - snap_f, 1);
    check_eq("low_no_valid", vcyc_a - snap_v, 0);
    check_eq("low_busy_end", busy_a, 0);
    check_eq("low_no_break", brk_cnt_a, 0);
`endif

    // reset in the middle of the data bits
    snap_v = vcyc_a;
    snap_f = ferr_cnt_a;
    fork
      send_frame(0, 8'h5A, 0, 1'b0, 1, 1'b1);
    join_none
    repeat (64) @(negedge clk);
    check_eq("mid_busy", busy_a, 1);
    check_eq("mid_state_data", dbg_a, 2);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_busy", busy_a, 0);
    check_eq("rst_mid_valid", a_if.m_valid, 0);
    check_eq("rst_mid_data", a_if.m_data, 0);
    check_eq("rst_mid_state", dbg_a, 0);
    wait fork;
    rst = 1'b0;
    idle_bits(0, 2);
    check_eq("rst_mid_no_valid", vcyc_a - snap_v, 0);
    check_eq("rst_mid_no_ferr", ferr_cnt_a - snap_f, 0);
    check_eq("a_no_err_overlap", both_a, 0);

    // even parity, two stop bits: wrong parity first
    send_frame(1, 8'h07, 1, 1'b0, 2, 1'b1);
    idle_bits(1, 2);
    check_eq("par_bad_valid", b_if.m_valid, 1);
    check_eq("par_bad_data", b_if.m_data, 8'h07);
    check_eq("par_bad_flag", b_if.m_parity_err, 1);
    @(posedge clk); #1 b_if.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("par_accept_drop", b_if.m_valid, 0);
    exp_q_b.push_back(9'h107);
    send_frame(1, 8'h07, 1, 1'b1, 2, 1'b1);
    idle_bits(1, 2);
    exp_q_b.push_back(9'h007);
    check_queue(1);

    // second stop bit low
    snap_v = vcyc_b;
    send_frame(1, 8'h3C, 1, 1'b0, 2, 1'b0);
    idle_bits(1, 2);
    check_eq("stop2_ferr_count", ferr_cnt_b, 1);
    check_eq("stop2_no_valid", vcyc_b - snap_v, 0);
    check_eq("stop2_busy_end", busy_b, 0);
    send_frame(1, 8'h3C, 1, 1'b0, 2, 1'b1);
    idle_bits(1, 2);
    exp_q_b.push_back(9'h03C);
    check_queue(1);
    check_eq("b_ovr_none", ovr_cnt_b, 0);
    check_eq("b_no_err_overlap", both_b, 0);
    check_eq("b_no_break", brk_cnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised next-generation UART receiver for the board-level serial link that feeds the AES datapath with plaintext and key bytes.
- Adds configurable data width, parity and stop bits, an input synchroniser, and a valid/ready output with a holding register.
- Reports parity, framing and overrun errors.
- Sits between the RsRx pin and the byte-assembly/command logic.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit (100 MHz / 9600 baud); must be >= 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk; idles high.
- m_data  out  DATA_BITS  received word, valid while m_valid=1.
- m_valid  out  1  word available; held until accepted.
- m_ready  in  1  consumer accepts; transfer occurs when m_valid && m_ready at a rising clk edge.
- m_parity_err  out  1  parity mismatch flag for the word in m_data; qualified by m_valid; 0 when PARITY_MODE=0.
- frame_err  out  1  one-cycle pulse: a stop bit sampled low.
- overrun  out  1  one-cycle pulse: a frame completed while m_valid=1.
- busy  out  1  high in any state other than IDLE.
- break_det  out  1  see Optional Feature.

Behaviour:
- Reset: clk and rst only, as already decided; rst is asynchronous and active-high. All outputs reset to 0, the state machine resets to IDLE, counters reset to 0, and both synchroniser flops reset to 1.
- Synchroniser: rx passes through 2 flops to form rx_s. Every reference below is to rx_s; the added latency is 2 cycles.
- Bit counter: width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 (integer division).
- IDLE: counter = 0 and bit index = 0. If rx_s == 0, go to START.
- START: count to HALF-1.
  - At terminal count, if rx_s == 1, this is a glitch: return to IDLE with no output.
  - Otherwise clear the counter and go to DATA.
- DATA: count to CLKS_PER_BIT-1. At terminal count, sample rx_s into shift[idx] and clear the counter.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else go to STOP.
- PARITY: one bit period, then sample. Expected bit = XOR of the data bits, inverted for odd parity. Latch mismatch into perr_int, then go to STOP.
- STOP: one bit period per stop bit; sample at each terminal count.
  - Any low sample sets ferr_int.
  - After the last stop sample (mid-bit), go to DONE. DONE takes 1 cycle, then returns to IDLE, so the next start edge can be detected immediately.
- DONE, evaluated in this order:
  - ferr_int = 1: pulse frame_err and discard the word.
  - Else if m_valid = 1 and not (m_ready = 1): pulse overrun. The old word and m_parity_err are kept and the new word is discarded.
  - Else: load m_data and m_parity_err, and set m_valid = 1. Accept and load in the same cycle is allowed: m_valid stays 1 and the new word replaces the old one.
- Handshake: m_valid falls on the cycle after acceptance, unless a reload happens in that same cycle. m_data is stable while m_valid=1 and not accepted.
- Latency: m_valid rises 1 cycle after the last stop-bit sample.
- Error pulses are exactly one cycle long. frame_err and overrun are never asserted in the same cycle.
- Reset mid-frame aborts the frame immediately and produces no output.
- A held-low line without break detection: a framing error, then a new START immediately. This repeats per frame time.

Optional Feature:
- UART_RX_BREAK_DETECT_EN defined:
  - A frame whose start, data, parity and all stop samples are 0 pulses break_det for 1 cycle, instead of frame_err, and discards the word.
  - The FSM then enters BRK_WAIT and stays there until rx_s == 1, then returns to IDLE. busy stays high in BRK_WAIT.
- Not defined: break_det is tied to 0 and BRK_WAIT does not exist. All-zero frames follow the normal framing-error path.

Test Plan:
- CLKS_PER_BIT=16, 8N1; send 0x55 then 0xA3 back-to-back with m_ready=1 -> m_data=0x55 then 0xA3, one m_valid cycle each, no error pulses.
- PARITY_MODE=2; send 0x07 with parity bit 0 (wrong) -> m_data=0x07, m_valid=1, m_parity_err=1; then send 0x07 with parity 1 -> m_parity_err=0.
- STOP_BITS=2; send 0x3C with the second stop bit low -> frame_err pulses once, m_valid stays 0; then a clean 0x3C is delivered.
- m_ready=0; send 0x11 then 0x22 -> m_data holds 0x11 and overrun pulses at the end of the second frame; raise m_ready -> 0x11 is accepted and m_valid drops.
- rx low pulse of 5 cycles (less than HALF) -> returns to IDLE with no outputs; assert rst mid-DATA -> all outputs 0 and busy=0 immediately.
- With UART_RX_BREAK_DETECT_EN: hold rx low for 30 bit times -> break_det pulses once, no frame_err, busy=1 until rx returns high, then a clean 0x5A is received.
